db_sao_band_stat: RTL and testbench
===================================

DB_SAO_BAND_STAT -- requirements
Module: db_sao_band_stat

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port start_i, input, 1: one-cycle pulse that opens a new CTB statistics window.
REQ-004 SHALL have port valid_i, input, 1: the current pixel's diff/index pair is valid.
REQ-005 SHALL have port last_i, input, 1: qualifies valid_i; marks the final pixel of the window.
REQ-006 SHALL have port ominusdp_i, input, 288: 32 packed signed 9-bit (orig minus deblocked) slices; slice b = bits [9b+8:9b].
REQ-007 SHALL have port index_i, input, 32: band flags; bit b set means slice b carries this pixel's diff.
REQ-008 SHALL have port busy_o, output, 1: high in ACC and OUT states.
REQ-009 SHALL have port stat_valid_o, output, 1: band_o, sum_o and cnt_o are valid this cycle.
REQ-010 SHALL have port band_o, output, 5: band number being emitted.
REQ-011 SHALL have port sum_o, output, 21: signed sum of diffs for band_o.
REQ-012 SHALL have port cnt_o, output, 13: unsigned pixel count for band_o.
REQ-013 SHALL have port done_o, output, 1: one-cycle pulse in the cycle after band 31 is emitted.

Function
REQ-014 SHALL implement FSM states IDLE, ACC and OUT.
REQ-015 SHALL, in IDLE with start_i=1, clear all 32 sums and counts and enter ACC next cycle.
REQ-016 SHALL, in ACC with valid_i=1, add sign-extended slice b to sum[b] and increment cnt[b] for every b with index_i[b]=1, in the same cycle.
REQ-017 SHALL, when multiple index bits are set, update every flagged band independently; with index_i=0, update nothing.
REQ-018 SHALL, in ACC with valid_i=1 and last_i=1, accumulate that pixel and enter OUT next cycle.
REQ-019 SHALL ignore last_i when valid_i=0.
REQ-020 SHALL, in ACC with start_i=1, clear all accumulators and remain in ACC; same-cycle valid_i is discarded, and start_i has priority over last_i.
REQ-021 SHALL, in OUT, emit bands 0..31 in ascending order, one per cycle, with stat_valid_o=1 for exactly 32 consecutive cycles.
REQ-022 SHALL assert stat_valid_o for band 0 in the first cycle after the last-pixel cycle (latency 1).
REQ-023 SHALL assert done_o, return to IDLE and deassert busy_o in the cycle after band 31.
REQ-024 SHALL ignore valid_i, last_i and start_i in OUT, and valid_i and last_i in IDLE.
REQ-025 SHALL saturate cnt at 8191, and SHALL wrap sum modulo 2^21 (two's complement); a 64x64 CTB (4096 px, |diff|<=255) cannot reach either limit.
REQ-026 SHALL drive band_o, sum_o and cnt_o to 0 whenever stat_valid_o=0.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, enter IDLE, clear all sums, counts and the output band counter, and drive busy_o, stat_valid_o, done_o, band_o, sum_o and cnt_o to 0.
REQ-028 SHALL let rst override start_i and valid_i in the same cycle; reset during ACC or OUT aborts the window with no done_o.

Structure
REQ-029 SHALL place NUM_BANDS=32, DIFF_W=9, SUM_W=21, CNT_W=13 and the FSM state encodings in a shared package.
REQ-030 SHALL instantiate 32 copies of one sub-module, db_sao_band_acc, each holding one band's sum and count with clear, enable and diff inputs.
REQ-031 SHALL register outputs; the OUT-state read SHALL be a 32:1 mux selected by the band counter.

Verification
REQ-032 SHALL cover: start, then 4 valid pixels in band 3 with diffs +5, -2, +7, -1 (last on the 4th) -> band 3 emits sum=9, cnt=4; all other bands emit 0/0.
REQ-033 SHALL cover: start, then 4096 pixels in band 31 each with diff -255 -> sum=-1044480, cnt=4096, with no wrap.
REQ-034 SHALL cover: start, 10 pixels in band 0 (diff +1), start again, 2 pixels in band 0 (diff +3, last) -> band 0 emits sum=6, cnt=2.
REQ-035 SHALL cover: a last pixel in cycle N -> stat_valid_o high in cycles N+1..N+32, band_o steps 0..31, done_o high only in cycle N+33, and busy_o low from N+33.
REQ-036 SHALL cover: rst asserted mid-OUT at band 10 -> next cycle all outputs 0 and state IDLE; the following start plus 1 pixel (band 5, diff -4, last) -> band 5 emits -4/1.
REQ-037 SHALL cover: index_i=0 with valid_i=1, and valid_i pulses during OUT -> no accumulator change.

Source files
------------

// File: rtl/db_sao_band_stat_pkg.sv
// Shared widths, FSM encoding and datatypes for the SAO band-offset
// statistics block.
package db_sao_band_stat_pkg;

    localparam int NUM_BANDS = 32;
    localparam int DIFF_W    = 9;
    localparam int SUM_W     = 21;
    localparam int CNT_W     = 13;
    localparam int BAND_W    = 5;
    localparam int OM_W      = NUM_BANDS * DIFF_W;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    typedef logic signed [SUM_W-1:0] sum_t;
    typedef logic [CNT_W-1:0]        cnt_t;
    typedef logic [BAND_W-1:0]       band_t;

    function automatic cnt_t cnt_inc(input cnt_t c);
        return (c == CNT_MAX) ? c : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/db_sao_band_stat_if.sv
// Pixel stream in, per-band statistics out.
interface db_sao_band_stat_if;
    import db_sao_band_stat_pkg::*;

    logic                 start_i;
    logic                 valid_i;
    logic                 last_i;
    logic [OM_W-1:0]      ominusdp_i;
    logic [NUM_BANDS-1:0] index_i;

    logic  busy_o;
    logic  stat_valid_o;
    band_t band_o;
    sum_t  sum_o;
    cnt_t  cnt_o;
    logic  done_o;

    modport master (
        output start_i, valid_i, last_i,
        output ominusdp_i, index_i,
        input  busy_o, stat_valid_o, band_o,
        input  sum_o, cnt_o, done_o
    );

    modport slave (
        input  start_i, valid_i, last_i,
        input  ominusdp_i, index_i,
        output busy_o, stat_valid_o, band_o,
        output sum_o, cnt_o, done_o
    );

endinterface

// File: rtl/db_sao_band_acc.sv
// One band's running diff sum (wrapping) and pixel count (saturating).
module db_sao_band_acc
    import db_sao_band_stat_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DIFF_W-1:0] diff,
    output sum_t                     sum_q,
    output cnt_t                     cnt_q
);

    sum_t sum_d;
    cnt_t cnt_d;

    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (clr) begin
            sum_d = '0;
            cnt_d = '0;
        end else if (en) begin
            sum_d = sum_q + SUM_W'(diff);
            cnt_d = cnt_inc(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/db_sao_band_stat.sv
// Collects per-band diff sums and counts over a CTB, then streams
// all 32 bands out in ascending order.
module db_sao_band_stat
    import db_sao_band_stat_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    db_sao_band_stat_if.slave bus
);

    state_t               state;
    band_t                bcnt;
    logic                 clr;
    logic                 acc_go;
    logic [NUM_BANDS-1:0] en;

    sum_t sum_q [NUM_BANDS];
    cnt_t cnt_q [NUM_BANDS];

    logic  busy_r;
    logic  sv_r;
    logic  done_r;
    band_t band_r;
    sum_t  sum_r;
    cnt_t  cnt_r;

    assign clr    = bus.start_i && (state != ST_OUT);
    assign acc_go = (state == ST_ACC) && bus.valid_i
                    && !bus.start_i;
    assign en     = acc_go ? bus.index_i : '0;

    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
        db_sao_band_acc u_acc (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .en    (en[b]),
            .diff  (bus.ominusdp_i[b*DIFF_W +: DIFF_W]),
            .sum_q (sum_q[b]),
            .cnt_q (cnt_q[b])
        );
    end

    // Band 0 leaves on the edge that also folds in the last pixel,
    // so its output value is taken from the accumulator's next state.
    logic signed [DIFF_W-1:0] diff0;
    sum_t                     sum0_nxt;
    cnt_t                     cnt0_nxt;

    assign diff0    = bus.ominusdp_i[DIFF_W-1:0];
    assign sum0_nxt = en[0] ? sum_q[0] + SUM_W'(diff0) : sum_q[0];
    assign cnt0_nxt = en[0] ? cnt_inc(cnt_q[0]) : cnt_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            bcnt   <= '0;
            busy_r <= 1'b0;
            sv_r   <= 1'b0;
            done_r <= 1'b0;
            band_r <= '0;
            sum_r  <= '0;
            cnt_r  <= '0;
        end else begin
            sv_r   <= 1'b0;
            done_r <= 1'b0;
            band_r <= '0;
            sum_r  <= '0;
            cnt_r  <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        state  <= ST_ACC;
                        busy_r <= 1'b1;
                    end
                end
                ST_ACC: begin
                    if (acc_go && bus.last_i) begin
                        state <= ST_OUT;
                        sv_r  <= 1'b1;
                        sum_r <= sum0_nxt;
                        cnt_r <= cnt0_nxt;
                        bcnt  <= band_t'(1);
                    end
                end
                ST_OUT: begin
                    if (band_r == band_t'(NUM_BANDS - 1)) begin
                        state  <= ST_IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        bcnt   <= '0;
                    end else begin
                        sv_r   <= 1'b1;
                        band_r <= bcnt;
                        sum_r  <= sum_q[bcnt];
                        cnt_r  <= cnt_q[bcnt];
                        bcnt   <= bcnt + band_t'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o       = busy_r;
    assign bus.stat_valid_o = sv_r;
    assign bus.done_o       = done_r;
    assign bus.band_o       = band_r;
    assign bus.sum_o        = sum_r;
    assign bus.cnt_o        = cnt_r;

endmodule

// File: tb/tb_db_sao_band_stat.sv
// Directed scenarios; expected band statistics are queued and a
// negedge monitor compares each emitted band against the queue.
module tb_db_sao_band_stat;

    typedef struct {
        int band;
        int sum;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    db_sao_band_stat_if bus ();

    db_sao_band_stat dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];
    int   exp_sum [32];
    int   exp_cnt [32];

    task automatic check(input string nm, input longint act,
                         input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [287:0] sl(input int b, input int d);
        logic [287:0] v;
        logic [8:0]   x;
        v = '0;
        x = 9'(d);
        v[9*b +: 9] = x;
        return v;
    endfunction

    function automatic logic [31:0] bit_of(input int b);
        logic [31:0] one;
        one = 32'd1;
        return one << b;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start_i    = 1'b0;
        bus.valid_i    = 1'b0;
        bus.last_i     = 1'b0;
        bus.index_i    = '0;
        bus.ominusdp_i = '0;
    endtask

    task automatic start_win();
        bus.start_i = 1'b1;
        cyc();
        bus.start_i = 1'b0;
    endtask

    task automatic pix(input logic [31:0] idx,
                       input logic [287:0] om, input bit last);
        bus.valid_i    = 1'b1;
        bus.last_i     = last;
        bus.index_i    = idx;
        bus.ominusdp_i = om;
        cyc();
        idle_inputs();
    endtask

    task automatic clear_exp();
        for (int b = 0; b < 32; b++) begin
            exp_sum[b] = 0;
            exp_cnt[b] = 0;
        end
    endtask

    task automatic push_exp();
        for (int b = 0; b < 32; b++)
            q.push_back('{b, exp_sum[b], exp_cnt[b]});
    endtask

    task automatic check_quiet(input string nm);
        check({nm, "_busy"}, bus.busy_o, 0);
        check({nm, "_sv"}, bus.stat_valid_o, 0);
        check({nm, "_done"}, bus.done_o, 0);
        check({nm, "_band"}, bus.band_o, 0);
        check({nm, "_sum"}, bus.sum_o, 0);
        check({nm, "_cnt"}, bus.cnt_o, 0);
    endtask

    // Called one step after the last-pixel edge (cycle N+1).
    task automatic out_phase(input bit noise);
        check("lat1_sv", bus.stat_valid_o, 1);
        check("lat1_band", bus.band_o, 0);
        for (int k = 1; k < 32; k++) begin
            if (noise) begin
                bus.valid_i    = 1'b1;
                bus.last_i     = 1'b1;
                bus.start_i    = 1'b1;
                bus.index_i    = '1;
                bus.ominusdp_i = '1;
            end
            cyc();
            check("out_sv", bus.stat_valid_o, 1);
            check("out_busy", bus.busy_o, 1);
            check("out_nodone", bus.done_o, 0);
        end
        idle_inputs();
        check("band31", bus.band_o, 31);
        cyc();
        check("done_hi", bus.done_o, 1);
        check("done_busy", bus.busy_o, 0);
        check("done_sv", bus.stat_valid_o, 0);
        cyc();
        check("done_pulse", bus.done_o, 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.stat_valid_o) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_band: got %0d expected none",
                             bus.band_o);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("band", bus.band_o, e.band);
                    check("sum", int'($signed(bus.sum_o)), e.sum);
                    check("cnt", bus.cnt_o, e.cnt);
                end
            end else begin
                check("idle_zero",
                      {bus.band_o, bus.sum_o, bus.cnt_o}, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        bus.start_i = 1'b1;
        bus.valid_i = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        idle_inputs();
        check_quiet("reset");
        mon_en = 1'b1;

        // band 3: +5 -2 +7 -1, an empty-index pixel, noise during OUT
        start_win();
        clear_exp();
        exp_sum[3] = 9;
        exp_cnt[3] = 4;
        push_exp();
        pix(bit_of(3), sl(3, 5), 0);
        pix(bit_of(3), sl(3, -2), 0);
        pix(32'd0, '1, 0);
        pix(bit_of(3), sl(3, 7), 0);
        pix(bit_of(3), sl(3, -1), 1);
        out_phase(1);

        // 4096 pixels of -255 in band 31
        start_win();
        clear_exp();
        exp_sum[31] = -1044480;
        exp_cnt[31] = 4096;
        push_exp();
        for (int i = 0; i < 4096; i++)
            pix(bit_of(31), sl(31, -255), i == 4095);
        out_phase(0);

        // restart mid-window; start beats a same-cycle last pixel
        start_win();
        for (int i = 0; i < 10; i++)
            pix(bit_of(0), sl(0, 1), 0);
        bus.start_i    = 1'b1;
        bus.valid_i    = 1'b1;
        bus.last_i     = 1'b1;
        bus.index_i    = bit_of(0);
        bus.ominusdp_i = sl(0, 100);
        cyc();
        idle_inputs();
        check("restart_busy", bus.busy_o, 1);
        check("restart_sv", bus.stat_valid_o, 0);
        clear_exp();
        exp_sum[0] = 6;
        exp_cnt[0] = 2;
        push_exp();
        pix(bit_of(0), sl(0, 3), 0);
        pix(bit_of(0), sl(0, 3), 1);
        out_phase(0);

        // several bands per pixel; last without valid is ignored
        start_win();
        clear_exp();
        exp_sum[1]  = 99;
        exp_cnt[1]  = 2;
        exp_sum[2]  = -50;
        exp_cnt[2]  = 1;
        exp_sum[30] = -1;
        exp_cnt[30] = 2;
        push_exp();
        pix(bit_of(1) | bit_of(2) | bit_of(30),
            sl(1, 100) | sl(2, -50) | sl(30, -256), 0);
        bus.last_i     = 1'b1;
        bus.index_i    = bit_of(2);
        bus.ominusdp_i = sl(2, 3);
        cyc();
        idle_inputs();
        check("nolast_sv", bus.stat_valid_o, 0);
        check("nolast_busy", bus.busy_o, 1);
        pix(bit_of(1) | bit_of(30), sl(1, -1) | sl(30, 255), 1);
        out_phase(0);

        // reset while emitting band 10
        start_win();
        clear_exp();
        exp_sum[2] = 7;
        exp_cnt[2] = 1;
        push_exp();
        pix(bit_of(2), sl(2, 7), 1);
        for (int k = 0; k < 10; k++)
            cyc();
        check("pre_rst_band", bus.band_o, 10);
        rst = 1'b1;
        bus.start_i = 1'b1;
        bus.valid_i = 1'b1;
        cyc();
        q.delete();
        rst = 1'b0;
        idle_inputs();
        check_quiet("mid_rst");
        cyc();
        check("rst_nodone", bus.done_o, 0);
        start_win();
        clear_exp();
        exp_sum[5] = -4;
        exp_cnt[5] = 1;
        push_exp();
        pix(bit_of(5), sl(5, -4), 1);
        out_phase(0);

        cyc();
        cyc();
        check("queue_empty", q.size(), 0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
